// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : valid/ready command port to APB SETUP/ACCESS master, one transfer
//            outstanding. Optional access timeout under `APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t r_state;

`ifdef APB_TIMEOUT_EN
  // Abort fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE) && !PRESET;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= S_IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err    <= 1'b0;
      r_wait_cnt <= 8'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_write ? cmd_wdata : '0;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_wait_cnt <= 8'd0;
`endif
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // PREADY wins over a timeout landing in the same cycle.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            r_state   <= S_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (r_wait_cnt == c_TIMEOUT_LAST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : directed + randomized bench for apb_master_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int n_checks = 0;
  int n_err    = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Expected bus state while a transfer (a, w, d) is active.
  task automatic chk_bus(input string ph, input logic en, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    chk({ph, ".psel"},    PSEL, 1'b1);
    chk({ph, ".penable"}, PENABLE, en);
    chk({ph, ".paddr"},   PADDR, a);
    chk({ph, ".pwrite"},  PWRITE, w);
    chk({ph, ".pwdata"},  PWDATA, w ? d : '0);
    chk({ph, ".ready"},   cmd_ready, 1'b0);
    chk({ph, ".rvalid"},  rsp_valid, 1'b0);
  endtask

  // One complete command; the slave stalls 'waits' ACCESS cycles then returns rd.
  // Command inputs are scrambled while busy to prove they are ignored.
  task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic [DW-1:0] rd);
    int  n;
    logic aborted;
    chk("idle.ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    PREADY = 1'($urandom);
    tick();
    chk_bus("setup", 1'b0, a, w, d);
    cmd_valid = 1'b1; cmd_write = ~w; cmd_addr = 8'h55 ^ 8'($urandom); cmd_wdata = $urandom;
    PREADY = 1'($urandom);
    tick();
    chk_bus("access", 1'b1, a, w, d);
    n = 0;
    aborted = 1'b0;
    while (n < waits) begin
      PREADY = 1'b0; PRDATA = $urandom;
      tick();
      n++;
`ifdef APB_TIMEOUT_EN
      if (n == TO) begin
        aborted = 1'b1;
        break;
      end
`endif
      chk_bus("wait", 1'b1, a, w, d);
    end
    if (!aborted) begin
      PREADY = 1'b1; PRDATA = rd;
      tick();
    end
    chk("rsp.valid",   rsp_valid, 1'b1);
    chk("rsp.err",     rsp_err, aborted);
    chk("rsp.rdata",   rsp_rdata, (aborted || w) ? '0 : rd);
    chk("rsp.psel",    PSEL, 1'b0);
    chk("rsp.penable", PENABLE, 1'b0);
    chk("rsp.paddr",   PADDR, a);
    chk("rsp.ready",   cmd_ready, 1'b1);
    cmd_valid = 1'b0; PREADY = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; PREADY = 1'b0; PRDATA = '0;
    tick(); tick();
    chk("rst.psel", PSEL, 1'b0);
    chk("rst.penable", PENABLE, 1'b0);
    chk("rst.pwrite", PWRITE, 1'b0);
    chk("rst.paddr", PADDR, '0);
    chk("rst.pwdata", PWDATA, '0);
    chk("rst.rvalid", rsp_valid, 1'b0);
    chk("rst.rdata", rsp_rdata, '0);
    chk("rst.err", rsp_err, 1'b0);
    chk("rst.ready", cmd_ready, 1'b0);
    PRESET = 1'b0;
    #1;
    chk("rel.ready", cmd_ready, 1'b1);
    tick();

    do_xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0);
    tick();
    chk("gap.rvalid", rsp_valid, 1'b0);
    do_xfer(1'b0, 8'h10, 32'h12345678, 3, 32'hDEADBEEF);

    // Back-to-back writes: next command presented on the response cycle.
    do_xfer(1'b1, 8'h01, 32'h1, 0, 32'h0);
    do_xfer(1'b1, 8'h02, 32'h2, 0, 32'h0);
    do_xfer(1'b1, 8'h03, 32'h3, 0, 32'h0);

    // PREADY on the last cycle before the timeout would fire completes normally.
    do_xfer(1'b0, 8'hA0, 32'h0, TO - 1, 32'hCAFEF00D);

    for (int i = 0; i < 40; i++)
      do_xfer(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 3)), $urandom);

`ifdef APB_TIMEOUT_EN
    do_xfer(1'b0, 8'h77, 32'h0, TO + 5, 32'hBAD0BAD0);
`else
    do_xfer(1'b0, 8'h77, 32'h0, 120, 32'h600DF00D);
`endif

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_wdata = '0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid.penable", PENABLE, 1'b1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("mid.psel", PSEL, 1'b0);
    chk("mid.penable0", PENABLE, 1'b0);
    chk("mid.rvalid", rsp_valid, 1'b0);
    chk("mid.ready", cmd_ready, 1'b0);
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1; PRDATA = 32'hFFFFFFFF;
    #1;
    chk("post.ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post.rvalid", rsp_valid, 1'b0);
      chk("post.psel", PSEL, 1'b0);
    end
    PREADY = 1'b0;
    do_xfer(1'b0, 8'h42, 32'h0, 1, 32'h0BADCAFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB slave: converts a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Returns one response per command (read data and error flag).
- Sits between the bus-functional request source (sequencer-driven command port) and the APB slave.
- Handles one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 8, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY. Used only when APB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- PCLK  input  1  single clock; all logic is on the rising edge.
- PRESET  input  1  reset, asynchronous and active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- rsp_err  output  1  transfer aborted by timeout.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_WIDTH  APB address.
- PWDATA  output  DATA_WIDTH  APB write data.
- PREADY  input  1  slave ready.
- PRDATA  input  DATA_WIDTH  slave read data.

Behaviour:
- Clock and reset: one clock (PCLK); reset PRESET is asynchronous and active-high.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- cmd_ready: combinational; equals (state==IDLE) && !PRESET.
- All APB and rsp outputs are registered.

State machine (IDLE, SETUP, ACCESS):
- IDLE: on cmd_valid && cmd_ready, latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA. PWDATA is driven 0 for reads. Set PSEL=1, PENABLE=0, go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, go to ACCESS.
- ACCESS:
  - PREADY=0: hold all APB outputs; stay in ACCESS (wait states unbounded unless timeout is enabled).
  - PREADY=1: capture PRDATA into rsp_rdata if read (else 0), set rsp_err=0, pulse rsp_valid for one cycle, clear PSEL and PENABLE, go to IDLE.
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the final ACCESS cycle. They keep their last values in IDLE.

Latency:
- Accept edge at T0; SETUP occupies T0–T1 and ACCESS begins at T1.
- With zero wait states, PREADY is sampled at T2 and rsp_valid is high T2–T3.
- cmd_ready is high again from T2, so the minimum command-to-command interval is 3 cycles.

Boundary conditions:
- cmd_valid while not in IDLE: ignored, no accept.
- cmd_valid and PREADY in the same cycle: a new command can only be accepted in IDLE, so there is never a simultaneous accept and complete.
- PREADY high during SETUP or IDLE: ignored.
- rsp_valid has no backpressure; the consumer must sample it on the pulse.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously, no response is issued, and the command is lost.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, abort: clear PSEL and PENABLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, go to IDLE.
  - If PREADY=1 in the same cycle the counter reaches TIMEOUT_CYCLES, complete normally (PREADY has priority).
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_err is constant 0.

Test Plan:
- Write, zero wait: cmd addr=0x10, wdata=0xDEADBEEF, PREADY=1 in ACCESS -> PSEL high 2 cycles, PENABLE 1 cycle, PWDATA=0xDEADBEEF stable, rsp_valid=1 with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states: addr=0x10, PREADY low for 3 ACCESS cycles then high with PRDATA=0xDEADBEEF -> PADDR held 5 cycles, rsp_rdata=0xDEADBEEF, rsp_valid exactly one cycle.
- Back-to-back: cmd_valid held high with writes to 0x01, 0x02, 0x03 -> three accepts spaced 3 cycles apart (zero wait), PSEL drops for one IDLE cycle between transfers.
- Busy ignore: change cmd_addr to 0x55 during ACCESS -> PADDR unchanged, cmd_ready=0, no extra transfer.
- Reset mid-ACCESS: assert PRESET while PENABLE=1 -> PSEL, PENABLE and rsp_valid are 0 immediately (before the next edge); after release, cmd_ready=1 and no stale response.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): PREADY held 0 -> after 4 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0; with the macro undefined, PSEL stays high for 100+ cycles.
